encoder_scan: RTL and testbench

//  Sequential 32-to-5 encoder; the inverse of our 5-to-32 one-hot decoder.

---
 rtl/encoder_scan.sv | 78 +++++++
 tb/tb_encoder_scan.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/encoder_scan.sv
// encoder_scan: sequential N-to-SEL_W encoder that emits one set-line index per valid/ack handshake.
// Define SCAN_MSB_FIRST_EN to emit indices in descending order. The default order is ascending.
module encoder_scan #(
   parameter int N = 32,
   parameter int SEL_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             load,
   input  logic [N-1:0]     lines,
   output logic             ready,
   output logic [SEL_W-1:0] selector,
   output logic             valid,
   input  logic             ack,
   output logic             done,
   output logic             empty
);
   typedef enum logic {IDLE, EMIT} state_t;
   state_t state;
   logic [N-1:0] pending, remain;
   logic [SEL_W-1:0] first, next;
   function automatic logic [SEL_W-1:0] pick(input logic [N-1:0] v);
      logic [SEL_W-1:0] r;
      r = '0;
`ifdef SCAN_MSB_FIRST_EN
      for (int i = 0; i < N; i++) if (v[i]) r = SEL_W'(i);
`else
      for (int i = N - 1; i >= 0; i--) if (v[i]) r = SEL_W'(i);
`endif
      return r;
   endfunction
   // remain is what is left once the code currently on the bus is transferred
   assign remain = pending & ~(N'(1) << selector);
   assign first = pick(pending);
   assign next = pick(remain);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pending  <= '0;
         selector <= '0;
         valid    <= 1'b0;
         done     <= 1'b0;
         empty    <= 1'b0;
         ready    <= 1'b1;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (enable && load) begin
               if (|lines) begin
                  pending <= lines;
                  empty   <= 1'b0;
                  ready   <= 1'b0;
                  state   <= EMIT;
               end else begin
                  done  <= 1'b1;
                  empty <= 1'b1;
               end
            end
         end else if (!enable) begin
            valid <= 1'b0;
         end else if (valid && ack) begin
            pending <= remain;
            if (|remain) begin
               selector <= next;
            end else begin
               valid <= 1'b0;
               done  <= 1'b1;
               ready <= 1'b1;
               state <= IDLE;
            end
         end else begin
            valid    <= 1'b1;
            selector <= first;
         end
      end
   end
endmodule

// File: tb/tb_encoder_scan.sv
// tb_encoder_scan: randomized scoreboard bench for encoder_scan; the expected code order comes from a set-bit list model.
module tb_encoder_scan;
   logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, load = 1'b0, ack = 1'b0;
   logic [31:0] lines = '0;
   logic ready, valid, done, empty;
   logic [4:0] selector;
   int total = 0, bad = 0;
   int q[$];
   int done_cnt = 0, exp_done = 0;
   bit rnd = 1'b0;
   bit prev_hold = 1'b0;
   logic [4:0] prev_sel = '0;

   encoder_scan dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .lines(lines),
      .ready(ready), .selector(selector), .valid(valid), .ack(ack),
      .done(done), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic void push_exp(input logic [31:0] v);
      for (int i = 0; i < 32; i++) begin
`ifdef SCAN_MSB_FIRST_EN
         if (v[31 - i]) q.push_back(31 - i);
`else
         if (v[i]) q.push_back(i);
`endif
      end
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold <= 1'b0;
      end else begin
         if (valid && done) begin
            total++; bad++;
            $display("FAIL done_with_valid: got done=1 valid=1 want not both");
         end
         if (prev_hold && valid) chk("hold_sel", 32'(selector), 32'(prev_sel));
         if (valid && ack && enable) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL extra_code: got %0d want none", selector);
            end else chk("code", 32'(selector), 32'(q.pop_front()));
         end
         if (done) done_cnt++;
         prev_hold <= valid && !(ack && enable);
         prev_sel  <= selector;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd) begin
         ack    = $urandom_range(0, 2) != 0;
         enable = $urandom_range(0, 5) != 0;
         load   = valid && ($urandom_range(0, 3) == 0);
         lines  = $urandom;
      end
   endtask

   task automatic accept(input logic [31:0] v);
      int n = 0;
      while (!ready && n < 50) begin step(); n++; end
      chk("ready_before_load", 32'(ready), 32'd1);
      lines = v; load = 1'b1; enable = 1'b1;
      step();
      load = 1'b0;
      exp_done++;
      if (v != 0) begin
         push_exp(v);
         chk("empty_clr", 32'(empty), 32'd0);
         chk("busy", 32'(ready), 32'd0);
      end else begin
         chk("empty_done", 32'(done), 32'd1);
         chk("empty_flag", 32'(empty), 32'd1);
         chk("empty_novalid", 32'(valid), 32'd0);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (done_cnt != exp_done && n < 500) begin step(); n++; end
      rnd = 1'b0; load = 1'b0; enable = 1'b1; ack = 1'b1;
      chk("drain_done", 32'(done_cnt), 32'(exp_done));
      chk("drain_queue", 32'(q.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [4:0] f;
      #12;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_empty", 32'(empty), 32'd0);
      chk("rst_sel", 32'(selector), 32'd0);
      step(); rst_n = 1'b1; step();
      // single line with ack held: one code then done on the following cycle
      ack = 1'b1;
      accept(32'h0000_0010);
      step();
      chk("single_valid", 32'(valid), 32'd1);
      chk("single_sel", 32'(selector), 32'd4);
      step();
      chk("single_done", 32'(done), 32'd1);
      chk("single_valid_off", 32'(valid), 32'd0);
      drain();
      // backpressure holds the first code
`ifdef SCAN_MSB_FIRST_EN
      f = 5'd13;
`else
      f = 5'd4;
`endif
      ack = 1'b0;
      accept(32'h0000_2010);
      step();
      for (int i = 0; i < 3; i++) begin
         chk("bp_sel", 32'(selector), 32'(f));
         step();
      end
      ack = 1'b1;
      drain();
      accept(32'h0);
      drain();
      chk("empty_hold", 32'(empty), 32'd1);
      // enable pause after the first transfer
      accept(32'h8000_0001);
      step();
      step();
      enable = 1'b0;
      step();
      chk("pause_valid", 32'(valid), 32'd0);
      step();
      step();
      chk("pause_valid2", 32'(valid), 32'd0);
      chk("pause_nodone", 32'(done_cnt), 32'(exp_done - 1));
      enable = 1'b1;
      drain();
      for (int s = 0; s < 32; s++) begin
         accept(32'd1 << s);
         drain();
      end
      // reset mid-scan discards pending with no done
      ack = 1'b0;
      accept(32'h0000_F0F0);
      step(); step();
      chk("pre_rst_valid", 32'(valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_ready", 32'(ready), 32'd1);
      chk("midrst_valid", 32'(valid), 32'd0);
      chk("midrst_sel", 32'(selector), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_empty", 32'(empty), 32'd0);
      q.delete();
      exp_done--;
      step(); rst_n = 1'b1; ack = 1'b1;
      step(); step();
      chk("post_rst_valid", 32'(valid), 32'd0);
      chk("post_rst_done", 32'(done_cnt), 32'(exp_done));
      for (int k = 0; k < 150; k++) begin
         logic [31:0] v;
         v = $urandom;
         if (k % 4 == 1) v = v & $urandom & $urandom;
         if (k % 17 == 3) v = 32'h0;
         accept(v);
         rnd = 1'b1;
         drain();
      end
      chk("final_queue", 32'(q.size()), 32'd0);
      chk("final_done", 32'(done_cnt), 32'(exp_done));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
